// File: rtl/trap_sequencer_if.sv
// Trap/mret request bundle, fetch-redirect strobe and CSR access port of the trap sequencer.
// master = sequencer side, slave = core/CSR-file side.
interface trap_sequencer_if #(
    parameter int CSR_ADDR_W = 12
);
    logic                  trap_req;
    logic [31:0]           trap_cause;
    logic [31:0]           trap_pc;
    logic [31:0]           trap_tval;
    logic                  mret_req;
    logic                  busy;
    logic                  redirect_valid;
    logic [31:0]           redirect_pc;
    logic                  csr_r_en;
    logic                  csr_w_en;
    logic [2:0]            csr_op;
    logic [CSR_ADDR_W-1:0] csr_addr;
    logic [31:0]           csr_wdata;
    logic [31:0]           csr_rdata;

    modport master (
        input  trap_req, trap_cause, trap_pc, trap_tval, mret_req, csr_rdata,
        output busy, redirect_valid, redirect_pc,
        output csr_r_en, csr_w_en, csr_op, csr_addr, csr_wdata
    );

    modport slave (
        output trap_req, trap_cause, trap_pc, trap_tval, mret_req, csr_rdata,
        input  busy, redirect_valid, redirect_pc,
        input  csr_r_en, csr_w_en, csr_op, csr_addr, csr_wdata
    );
endinterface

// File: rtl/trap_sequencer.sv
// Sequences machine-mode trap entry (mepc/mcause/mtval/mstatus/mtvec) and mret CSR traffic.
// Latency: redirect 7 cycles after trap accept, 4 after mret accept.
// Backpressure: none; requests are only accepted in IDLE and ignored while busy.
module trap_sequencer #(
    parameter int CSR_ADDR_W = 12,
    parameter bit VEC_EN     = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    trap_sequencer_if.master bus
);
    localparam logic [CSR_ADDR_W-1:0] A_MSTATUS = CSR_ADDR_W'(12'h300);
    localparam logic [CSR_ADDR_W-1:0] A_MTVEC   = CSR_ADDR_W'(12'h305);
    localparam logic [CSR_ADDR_W-1:0] A_MEPC    = CSR_ADDR_W'(12'h341);
    localparam logic [CSR_ADDR_W-1:0] A_MCAUSE  = CSR_ADDR_W'(12'h342);
    localparam logic [CSR_ADDR_W-1:0] A_MTVAL   = CSR_ADDR_W'(12'h343);
    localparam logic [2:0]            OP_NONE   = 3'b000;
    localparam logic [2:0]            OP_WRITE  = 3'b001;

    typedef enum logic [3:0] {
        IDLE, W_MEPC, W_MCAUSE, W_MTVAL, R_MSTATUS, W_MSTATUS, R_MTVEC, R_MEPC, REDIRECT
    } state_t;

    state_t      state;
    logic        in_trap;
    logic [31:0] cause_q;
    logic [31:0] tval_q;
    logic [31:0] target_q;

    function automatic logic [31:0] trap_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r        = ms;
        r[7]     = ms[3];
        r[3]     = 1'b0;
        r[12:11] = 2'b11;
        return r;
    endfunction

    function automatic logic [31:0] mret_mstatus(input logic [31:0] ms);
        logic [31:0] r;
        r        = ms;
        r[3]     = ms[7];
        r[7]     = 1'b1;
        r[12:11] = 2'b00;
        return r;
    endfunction

    assign bus.busy = (state != IDLE);

    // CSR strobes are registered alongside the state they belong to, so they are valid for the whole state cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state              <= IDLE;
            in_trap            <= 1'b0;
            cause_q            <= '0;
            tval_q             <= '0;
            target_q           <= '0;
            bus.redirect_valid <= 1'b0;
            bus.redirect_pc    <= '0;
            bus.csr_r_en       <= 1'b0;
            bus.csr_w_en       <= 1'b0;
            bus.csr_op         <= OP_NONE;
            bus.csr_addr       <= '0;
            bus.csr_wdata      <= '0;
        end else begin
            bus.redirect_valid <= 1'b0;
            bus.csr_r_en       <= 1'b0;
            bus.csr_w_en       <= 1'b0;
            bus.csr_op         <= OP_NONE;
            bus.csr_addr       <= '0;
            bus.csr_wdata      <= '0;
            case (state)
                IDLE: begin
                    if (bus.trap_req) begin
                        cause_q       <= bus.trap_cause;
                        tval_q        <= bus.trap_tval;
                        in_trap       <= 1'b1;
                        state         <= W_MEPC;
                        bus.csr_w_en  <= 1'b1;
                        bus.csr_op    <= OP_WRITE;
                        bus.csr_addr  <= A_MEPC;
                        bus.csr_wdata <= bus.trap_pc & 32'hFFFF_FFFC;
                    end else if (bus.mret_req) begin
                        in_trap      <= 1'b0;
                        state        <= R_MEPC;
                        bus.csr_r_en <= 1'b1;
                        bus.csr_addr <= A_MEPC;
                    end
                end
                W_MEPC: begin
                    state         <= W_MCAUSE;
                    bus.csr_w_en  <= 1'b1;
                    bus.csr_op    <= OP_WRITE;
                    bus.csr_addr  <= A_MCAUSE;
                    bus.csr_wdata <= cause_q;
                end
                W_MCAUSE: begin
                    state         <= W_MTVAL;
                    bus.csr_w_en  <= 1'b1;
                    bus.csr_op    <= OP_WRITE;
                    bus.csr_addr  <= A_MTVAL;
                    bus.csr_wdata <= tval_q;
                end
                W_MTVAL, R_MEPC: begin
                    if (state == R_MEPC) target_q <= bus.csr_rdata & 32'hFFFF_FFFC;
                    state        <= R_MSTATUS;
                    bus.csr_r_en <= 1'b1;
                    bus.csr_addr <= A_MSTATUS;
                end
                R_MSTATUS: begin
                    state         <= W_MSTATUS;
                    bus.csr_w_en  <= 1'b1;
                    bus.csr_op    <= OP_WRITE;
                    bus.csr_addr  <= A_MSTATUS;
                    bus.csr_wdata <= in_trap ? trap_mstatus(bus.csr_rdata)
                                             : mret_mstatus(bus.csr_rdata);
                end
                W_MSTATUS: begin
                    if (in_trap) begin
                        state        <= R_MTVEC;
                        bus.csr_r_en <= 1'b1;
                        bus.csr_addr <= A_MTVEC;
                    end else begin
                        state              <= REDIRECT;
                        bus.redirect_valid <= 1'b1;
                        bus.redirect_pc    <= target_q;
                    end
                end
                R_MTVEC: begin
                    // Vectored dispatch only for interrupts; the shifted cause wraps modulo 2^32.
                    if (VEC_EN && bus.csr_rdata[1:0] == 2'b01 && cause_q[31]) begin
                        target_q        <= (bus.csr_rdata & 32'hFFFF_FFFC) + {cause_q[29:0], 2'b00};
                        bus.redirect_pc <= (bus.csr_rdata & 32'hFFFF_FFFC) + {cause_q[29:0], 2'b00};
                    end else begin
                        target_q        <= bus.csr_rdata & 32'hFFFF_FFFC;
                        bus.redirect_pc <= bus.csr_rdata & 32'hFFFF_FFFC;
                    end
                    state              <= REDIRECT;
                    bus.redirect_valid <= 1'b1;
                end
                REDIRECT: state <= IDLE;
                default:  state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/trap_sequencer.md
TRAP_SEQUENCER -- requirements
Module: trap_sequencer

Interface
REQ-001 Parameters SHALL be (name, default, meaning): CSR_ADDR_W, 12, CSR address width; VEC_EN, 1, 1 enables vectored-mode interrupt dispatch.
REQ-002 Design SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be (name direction width meaning):
- clk  in  1  clock
- rst  in  1  async active-high reset
- trap_req  in  1  trap request pulse/level
- trap_cause  in  32  mcause value; bit31=interrupt
- trap_pc  in  32  faulting PC
- trap_tval  in  32  trap value for mtval
- mret_req  in  1  return-from-trap request
- busy  out  1  sequencer not in IDLE
- redirect_valid  out  1  one-cycle fetch-redirect strobe
- redirect_pc  out  32  redirect target
- csr_r_en  out  1  CSR read enable
- csr_w_en  out  1  CSR write enable
- csr_op  out  3  001 write, 010 set, 011 clear
- csr_addr  out  CSR_ADDR_W  CSR address
- csr_wdata  out  32  CSR write data
- csr_rdata  in  32  CSR read data, combinational, valid same cycle as csr_r_en

Function
REQ-004 CSR addresses SHALL be mstatus 0x300, mtvec 0x305, mepc 0x341, mcause 0x342, mtval 0x343.
REQ-005 FSM states SHALL be IDLE, W_MEPC, W_MCAUSE, W_MTVAL, R_MSTATUS, W_MSTATUS, R_MTVEC, R_MEPC, REDIRECT.
REQ-006 In IDLE, trap_req=1 SHALL latch cause/pc/tval and go to W_MEPC; trap_req has priority over simultaneous mret_req.
REQ-007 In IDLE, mret_req=1 with trap_req=0 SHALL go to R_MEPC.
REQ-008 Trap path SHALL be W_MEPC -> W_MCAUSE -> W_MTVAL -> R_MSTATUS -> W_MSTATUS -> R_MTVEC -> REDIRECT -> IDLE, one cycle per state.
REQ-009 mret path SHALL be R_MEPC -> R_MSTATUS -> W_MSTATUS -> REDIRECT -> IDLE, one cycle per state.
REQ-010 Write states SHALL drive csr_w_en=1, csr_op=001, csr_r_en=0; W_MEPC writes latched pc with bits[1:0] cleared, W_MCAUSE latched cause, W_MTVAL latched tval.
REQ-011 Read states SHALL drive csr_r_en=1, csr_w_en=0, csr_op=000, csr_wdata=0, and register csr_rdata at the cycle's end.
REQ-012 Trap W_MSTATUS data SHALL equal read mstatus with bit7(MPIE)=old bit3(MIE), bit3=0, bits[12:11]=11, other bits unchanged.
REQ-013 mret W_MSTATUS data SHALL equal read mstatus with bit3=old bit7, bit7=1, bits[12:11]=00.
REQ-014 Trap target: base={mtvec[31:2],2'b00}; if VEC_EN=1, mtvec[1:0]=01 and cause[31]=1, target=base+(cause[30:0]<<2) truncated to 32 bits; else target=base.
REQ-015 mret target SHALL be {mepc[31:2],2'b00}.
REQ-016 redirect_valid SHALL be 1 only in REDIRECT, with redirect_pc=target; redirect_pc SHALL hold last target otherwise.
REQ-017 busy SHALL be 1 in every state except IDLE; trap_req/mret_req SHALL be ignored while busy, including during REDIRECT.
REQ-018 Latency: request sampled at edge N -> redirect_valid high in cycle after edge N+6 (trap) or N+3 (mret).
REQ-019 csr_r_en and csr_w_en SHALL never be 1 simultaneously; in IDLE and REDIRECT all csr_* outputs SHALL be 0.

Reset
REQ-020 rst=1 SHALL asynchronously force IDLE and clear latched cause/pc/tval/target and mstatus capture.
REQ-021 During and after reset all outputs SHALL be 0 (busy, redirect_valid, redirect_pc, csr_*).
REQ-022 Reset mid-sequence SHALL abort with no further CSR access; no redirect_valid for the aborted request.

Verification
REQ-023 Trap: cause=11, pc=0x0000_1002, tval=0, mtvec=0x0000_0100, mstatus=0x8 -> writes mepc=0x1000, mcause=11, mtval=0, mstatus=0x1880; redirect_pc=0x100 on 7th cycle.
REQ-024 Vectored interrupt: mtvec=0x0000_0201, cause=0x8000_0007 -> redirect_pc=0x0000_021C; with VEC_EN=0 -> 0x0000_0200.
REQ-025 mret: mepc=0x0000_2004, mstatus=0x1880 -> mstatus write 0x0088, redirect_pc=0x2004 on 4th cycle.
REQ-026 Simultaneous trap_req and mret_req in IDLE -> trap path taken; mret_req held during busy ignored; new request accepted only once busy=0.
REQ-027 rst asserted in R_MSTATUS of trap -> all outputs 0 immediately, no W_MSTATUS write, no redirect_valid.
